// File: rtl/gpu_row_compositor_if.sv
// Op and framebuffer bus for the row compositor: per-cycle calc ops in,
// committed rows out over valid/ready.
interface gpu_row_compositor_if #(
  parameter int PIX_W = 8
);
  logic                  i_calc_ena;
  logic [3:0]            i_calc_start_x;
  logic [7:0]            i_calc_position_z;
  logic [5:0]            i_tile_x;
  logic [5:0]            i_tile_y;
  logic [3:0]            i_tile_row;
  logic [16*PIX_W-1:0]   i_texture_row_data;
  logic                  o_fb_valid;
  logic                  i_fb_ready;
  logic [5:0]            o_fb_x;
  logic [8:0]            o_fb_y;
  logic [16*PIX_W-1:0]   o_fb_data;

  modport slave (
    input  i_calc_ena, i_calc_start_x, i_calc_position_z, i_tile_x, i_tile_y,
           i_tile_row, i_texture_row_data, i_fb_ready,
    output o_fb_valid, o_fb_x, o_fb_y, o_fb_data
  );

  modport master (
    output i_calc_ena, i_calc_start_x, i_calc_position_z, i_tile_x, i_tile_y,
           i_tile_row, i_texture_row_data, i_fb_ready,
    input  o_fb_valid, o_fb_x, o_fb_y, o_fb_data
  );
endinterface

// File: rtl/gpu_row_compositor.sv
// Composites sprite/background texture rows into a z-resolved 16-pixel tile row;
// the background op closes the row and pushes it into a small FIFO toward the framebuffer.
module gpu_row_compositor #(
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpu_row_compositor_if.slave   bus,
  output logic [LW-1:0]         o_fifo_level,
  output logic                  o_overflow,
  input  logic                  i_clear_overflow
);

  // S0 op capture
  logic       s0_valid_q, s0_valid_d;
  logic [7:0] s0_z_q,     s0_z_d;
  logic [3:0] s0_sx_q,    s0_sx_d;
  logic [5:0] s0_tx_q,    s0_tx_d;
  logic [5:0] s0_ty_q,    s0_ty_d;
  logic [3:0] s0_tr_q,    s0_tr_d;

  always_comb begin
    s0_valid_d = bus.i_calc_ena;
    s0_z_d     = s0_z_q;
    s0_sx_d    = s0_sx_q;
    s0_tx_d    = s0_tx_q;
    s0_ty_d    = s0_ty_q;
    s0_tr_d    = s0_tr_q;
    if (bus.i_calc_ena) begin
      s0_z_d  = bus.i_calc_position_z;
      s0_sx_d = bus.i_calc_start_x;
      s0_tx_d = bus.i_tile_x;
      s0_ty_d = bus.i_tile_y;
      s0_tr_d = bus.i_tile_row;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_q <= 1'b0;
      s0_z_q     <= '0;
      s0_sx_q    <= '0;
      s0_tx_q    <= '0;
      s0_ty_q    <= '0;
      s0_tr_q    <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_z_q     <= s0_z_d;
      s0_sx_q    <= s0_sx_d;
      s0_tx_q    <= s0_tx_d;
      s0_ty_q    <= s0_ty_d;
      s0_tr_q    <= s0_tr_d;
    end
  end

  // S1 merge against the row buffer
  logic [15:0]          pv_q, pv_d;
  logic [7:0]           zbuf_q [16];
  logic [7:0]           zbuf_d [16];
  logic [PIX_W-1:0]     pix_q  [16];
  logic [PIX_W-1:0]     pix_d  [16];
  logic [PIX_W-1:0]     tex_pix    [16];
  logic [PIX_W-1:0]     merged_pix [16];
  logic                 wr_en      [16];
  logic [16*PIX_W-1:0]  merged_data;
  logic                 is_bg;
  logic                 commit;

  assign is_bg  = (s0_z_q == 8'd0);
  assign commit = s0_valid_q && is_bg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pix
      logic [3:0]       src_j;
      logic             in_range;
      logic [PIX_W-1:0] src_pix;
      logic             sprite_wins;

      assign tex_pix[gi] = bus.i_texture_row_data[gi*PIX_W +: PIX_W];
      assign src_j       = 4'(gi) - s0_sx_q;
      assign in_range    = (4'(gi) >= s0_sx_q);
      assign src_pix     = is_bg ? tex_pix[gi] : tex_pix[src_j];
      // Strict greater-than: equal depth keeps the pixel that arrived first.
      assign sprite_wins = in_range && (src_pix != '0) &&
                           (!pv_q[gi] || (s0_z_q > zbuf_q[gi]));
      assign wr_en[gi]   = s0_valid_q && (is_bg ? !pv_q[gi] : sprite_wins);
      assign merged_pix[gi] = wr_en[gi] ? src_pix : pix_q[gi];
      assign merged_data[gi*PIX_W +: PIX_W] = merged_pix[gi];
    end
  endgenerate

  always_comb begin
    for (int p = 0; p < 16; p++) begin
      pv_d[p]   = commit ? 1'b0 : (pv_q[p] | wr_en[p]);
      zbuf_d[p] = wr_en[p] ? s0_z_q : zbuf_q[p];
      pix_d[p]  = merged_pix[p];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      for (int p = 0; p < 16; p++) begin
        zbuf_q[p] <= '0;
        pix_q[p]  <= '0;
      end
    end else begin
      pv_q <= pv_d;
      for (int p = 0; p < 16; p++) begin
        zbuf_q[p] <= zbuf_d[p];
        pix_q[p]  <= pix_d[p];
      end
    end
  end

  // Screen line: tile_y*16 + tile_row; tile_y <= 29 keeps it inside 9 bits.
  logic [9:0] y_full;
  logic [8:0] commit_y;
  logic       unused_y_msb;
  assign y_full       = {s0_ty_q, 4'b0000} + {6'b0, s0_tr_q};
  assign commit_y     = y_full[8:0];
  assign unused_y_msb = y_full[9];

  // Committed-row FIFO
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q,  level_d;
  logic                 ovf_q,    ovf_d;
  logic [16*PIX_W-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [5:0]           fifo_x_q    [FIFO_DEPTH];
  logic [8:0]           fifo_y_q    [FIFO_DEPTH];
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 drop;

  assign fifo_full = (level_q == LW'(FIFO_DEPTH));
  assign pop       = (level_q != '0) && bus.i_fb_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push      = commit && (!fifo_full || pop);
  assign drop      = commit && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (i_clear_overflow)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= merged_data;
      fifo_x_q[wr_ptr_q]    <= s0_tx_q;
      fifo_y_q[wr_ptr_q]    <= commit_y;
    end
  end

  // Outputs are forced to zero when empty so storage needs no reset.
  assign bus.o_fb_valid = (level_q != '0);
  assign bus.o_fb_x     = bus.o_fb_valid ? fifo_x_q[rd_ptr_q]    : '0;
  assign bus.o_fb_y     = bus.o_fb_valid ? fifo_y_q[rd_ptr_q]    : '0;
  assign bus.o_fb_data  = bus.o_fb_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign o_fifo_level   = level_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_gpu_row_compositor.sv
// Scoreboard bench for gpu_row_compositor: directed scenarios plus random ops,
// expected rows from a sprite-list reference model, checked by a separate monitor.
module tb_gpu_row_compositor;
  localparam int PW = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr;
  logic [LW-1:0] level;
  logic          ovf;

  gpu_row_compositor_if #(.PIX_W(PW)) bus();

  gpu_row_compositor #(.PIX_W(PW), .FIFO_DEPTH(D)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .o_fifo_level     (level),
    .o_overflow       (ovf),
    .i_clear_overflow (clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ena;
    logic [7:0]   z;
    logic [3:0]   sx;
    logic [5:0]   tx;
    logic [5:0]   ty;
    logic [3:0]   tr;
    logic [127:0] tex;
  } op_t;

  typedef struct packed {
    logic [5:0]   x;
    logic [8:0]   y;
    logic [127:0] data;
  } row_t;

  row_t exp_q[$];
  op_t  spr_q[$];
  op_t  m_s0;
  logic m_s0_v  = 1'b0;
  int   m_level = 0;
  logic m_ovf   = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  logic [127:0] prev_tex = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] b);
    logic [127:0] t;
    for (int j = 0; j < 16; j++) t[j*8 +: 8] = b;
    return t;
  endfunction

  function automatic logic [127:0] rnd_tex(input int zero_pct);
    logic [127:0] t;
    for (int j = 0; j < 16; j++)
      t[j*8 +: 8] = ($urandom_range(0, 99) < zero_pct) ? 8'h00 : 8'($urandom_range(1, 255));
    return t;
  endfunction

  function automatic op_t mk(input logic [7:0] z, input logic [3:0] sx, input logic [5:0] tx,
                             input logic [5:0] ty, input logic [3:0] tr, input logic [127:0] tex);
    op_t o;
    o.ena = 1'b1; o.z = z; o.sx = sx; o.tx = tx; o.ty = ty; o.tr = tr; o.tex = tex;
    return o;
  endfunction

  function automatic op_t idle();
    op_t o;
    o = mk(8'($urandom), 4'($urandom), 6'($urandom), 6'($urandom), 4'($urandom), rnd_tex(0));
    o.ena = 1'b0;
    return o;
  endfunction

  // Each pixel shows the deepest-z opaque sprite covering it (earliest on ties), else background.
  function automatic row_t compose(input op_t bg);
    row_t r;
    r.x = bg.tx;
    r.y = 9'(int'(bg.ty) * 16 + int'(bg.tr));
    for (int p = 0; p < 16; p++) begin
      int         best = -1;
      int         bz   = 0;
      logic [7:0] bp   = 8'h00;
      for (int i = 0; i < spr_q.size(); i++) begin
        op_t s = spr_q[i];
        int  j = p - int'(s.sx);
        if (j >= 0) begin
          logic [7:0] v = s.tex[j*8 +: 8];
          if (v != 8'h00 && (best < 0 || int'(s.z) > bz)) begin
            best = i; bz = int'(s.z); bp = v;
          end
        end
      end
      r.data[p*8 +: 8] = (best >= 0) ? bp : bg.tex[p*8 +: 8];
    end
    return r;
  endfunction

  // Reference model: an op is resolved the cycle after issue, when its texture is on the bus.
  op_t  m_cur;
  logic m_pop, m_drop;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s0_v  = 1'b0;
      spr_q.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
    end else begin
      m_pop  = (m_level > 0) && bus.i_fb_ready;
      m_drop = 1'b0;
      if (m_s0_v) begin
        m_cur     = m_s0;
        m_cur.tex = bus.i_texture_row_data;
        if (m_cur.z == 8'd0) begin
          if (m_level == D && !m_pop) m_drop = 1'b1;
          else begin
            exp_q.push_back(compose(m_cur));
            m_level++;
          end
          spr_q.delete();
        end else begin
          spr_q.push_back(m_cur);
        end
      end
      if (m_pop) m_level--;
      if (m_drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_s0_v = bus.i_calc_ena;
      m_s0   = mk(bus.i_calc_position_z, bus.i_calc_start_x, bus.i_tile_x,
                  bus.i_tile_y, bus.i_tile_row, '0);
    end
  end

  row_t mon_e;
  always @(negedge clk) begin
    chk("level", 128'(level), 128'(m_level));
    chk("overflow", 128'(ovf), 128'(m_ovf));
    chk("valid", 128'(bus.o_fb_valid), 128'(m_level > 0));
    if (bus.o_fb_valid && bus.i_fb_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL row_unexpected: got x=%0d y=%0d expected no row", bus.o_fb_x, bus.o_fb_y);
      end else begin
        mon_e = exp_q.pop_front();
        chk("row_x", 128'(bus.o_fb_x), 128'(mon_e.x));
        chk("row_y", 128'(bus.o_fb_y), 128'(mon_e.y));
        chk("row_data", bus.o_fb_data, mon_e.data);
      end
    end
  end

  task automatic step(input op_t op, input logic rdy, input logic c, input logic rn);
    @(posedge clk); #1;
    reset_n                = rn;
    bus.i_calc_ena         = op.ena;
    bus.i_calc_position_z  = op.z;
    bus.i_calc_start_x     = op.sx;
    bus.i_tile_x           = op.tx;
    bus.i_tile_y           = op.ty;
    bus.i_tile_row         = op.tr;
    bus.i_texture_row_data = prev_tex;
    prev_tex               = op.ena ? op.tex : rnd_tex(0);
    bus.i_fb_ready         = rdy;
    clr                    = c;
  endtask

  task automatic idles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(idle(), rdy, 1'b0, 1'b1);
  endtask

  // Bg op issued, then sample the head two cycles later while ready stays high.
  task automatic bg_and_peek(input op_t bg, input logic [5:0] ex, input logic [8:0] ey,
                             input logic [127:0] ed, input string tag);
    step(bg, 1'b1, 1'b0, 1'b1);
    idles(2, 1'b1);
    @(negedge clk);
    chk({tag, "_valid"}, 128'(bus.o_fb_valid), 128'(1));
    chk({tag, "_x"}, 128'(bus.o_fb_x), 128'(ex));
    chk({tag, "_y"}, 128'(bus.o_fb_y), 128'(ey));
    chk({tag, "_data"}, bus.o_fb_data, ed);
  endtask

  logic [127:0] t_tex;
  op_t          r_op;
  initial begin
    reset_n = 1'b0; clr = 1'b0;
    bus.i_calc_ena = 1'b0; bus.i_calc_position_z = '0; bus.i_calc_start_x = '0;
    bus.i_tile_x = '0; bus.i_tile_y = '0; bus.i_tile_row = '0;
    bus.i_texture_row_data = '0; bus.i_fb_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x", 128'(bus.o_fb_x), 128'(0));
    chk("rst_y", 128'(bus.o_fb_y), 128'(0));
    chk("rst_data", bus.o_fb_data, 128'(0));
    idles(2, 1'b1);

    // T1: background only, pixels 1..16
    for (int j = 0; j < 16; j++) t_tex[j*8 +: 8] = 8'(j + 1);
    bg_and_peek(mk(8'd0, 4'd0, 6'd3, 6'd2, 4'd5, t_tex), 6'd3, 9'd37, t_tex, "t1");
    idles(3, 1'b1);

    // T2: sprite offset 2 with transparent first texel, then background 0x11
    t_tex = fill(8'hAA); t_tex[7:0] = 8'h00;
    step(mk(8'd4, 4'd2, 6'd1, 6'd1, 4'd0, t_tex), 1'b1, 1'b0, 1'b1);
    t_tex = fill(8'hAA); t_tex[23:0] = 24'h111111;
    bg_and_peek(mk(8'd0, 4'd0, 6'd1, 6'd1, 4'd0, fill(8'h11)), 6'd1, 9'd16, t_tex, "t2");
    idles(3, 1'b1);

    // T3: z ordering and equal-z tie
    step(mk(8'd3, 4'd0, 6'd5, 6'd29, 4'd15, fill(8'h33)), 1'b1, 1'b0, 1'b1);
    step(mk(8'd7, 4'd0, 6'd5, 6'd29, 4'd15, fill(8'h77)), 1'b1, 1'b0, 1'b1);
    step(mk(8'd7, 4'd0, 6'd5, 6'd29, 4'd15, fill(8'h99)), 1'b1, 1'b0, 1'b1);
    bg_and_peek(mk(8'd0, 4'd0, 6'd5, 6'd29, 4'd15, fill(8'h55)), 6'd5, 9'd479, fill(8'h77), "t3");
    idles(3, 1'b1);

    // T4: backpressure overflow, drain, clear
    for (int k = 0; k < 5; k++)
      step(mk(8'd0, 4'd0, 6'(k), 6'd4, 4'(k), rnd_tex(0)), 1'b0, 1'b0, 1'b1);
    idles(3, 1'b0);
    @(negedge clk);
    chk("t4_level", 128'(level), 128'(4));
    chk("t4_ovf", 128'(ovf), 128'(1));
    idles(6, 1'b1);
    step(idle(), 1'b1, 1'b1, 1'b1);
    idles(2, 1'b1);
    @(negedge clk);
    chk("t4_ovf_clr", 128'(ovf), 128'(0));

    // T5: commit into a full FIFO while popping
    for (int k = 0; k < 4; k++)
      step(mk(8'd0, 4'd0, 6'(10 + k), 6'd6, 4'(k), rnd_tex(0)), 1'b0, 1'b0, 1'b1);
    idles(2, 1'b0);
    step(mk(8'd0, 4'd0, 6'd20, 6'd7, 4'd1, rnd_tex(0)), 1'b0, 1'b0, 1'b1);
    idles(1, 1'b1);
    idles(2, 1'b0);
    @(negedge clk);
    chk("t5_level", 128'(level), 128'(4));
    chk("t5_ovf", 128'(ovf), 128'(0));
    idles(6, 1'b1);

    // T6: reset between a sprite and the background
    step(mk(8'd5, 4'd0, 6'd8, 6'd3, 4'd2, fill(8'h66)), 1'b1, 1'b0, 1'b1);
    step(idle(), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_rst_level", 128'(level), 128'(0));
    bg_and_peek(mk(8'd0, 4'd0, 6'd8, 6'd3, 4'd2, fill(8'h22)), 6'd8, 9'd50, fill(8'h22), "t6");
    idles(3, 1'b1);

    // Random ops with random backpressure and overflow clears
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 4) == 0)
          r_op = mk(8'd0, 4'd0, 6'($urandom_range(0, 39)), 6'($urandom_range(0, 29)),
                    4'($urandom), rnd_tex(20));
        else
          r_op = mk(8'($urandom_range(1, 8)), 4'($urandom), 6'($urandom_range(0, 39)),
                    6'($urandom_range(0, 29)), 4'($urandom), rnd_tex(30));
      end else begin
        r_op = idle();
      end
      step(r_op, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), 1'b1);
    end
    idles(12, 1'b1);
    @(negedge clk);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
